// File: rtl/arb_pkg.sv
// Shared types and helpers for the shared-bus arbiter.
// States, the high-priority index and a one-hot helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_HP,
        GRANT_LP
    } arb_state_e;

    localparam int HP_IDX   = 0;
    localparam int ONEHOT_W = 32;

    function automatic logic [ONEHOT_W-1:0] onehot(input int idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_if.sv
// Request/grant bundle between the requesting modules and the shared-bus arbiter.
// master = requester side, slave = arbiter side.
interface shared_bus_arbiter_if #(
    parameter int N  = 3,
    parameter int CW = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  grant;
    logic [IW-1:0] owner;
    logic          busy;
    logic [CW-1:0] preempt_cnt;
    logic          wd_err;
    logic [IW-1:0] wd_id;

    modport master (
        output req, done,
        input  grant, owner, busy, preempt_cnt, wd_err, wd_id
    );

    modport slave (
        input  req, done,
        output grant, owner, busy, preempt_cnt, wd_err, wd_id
    );
endinterface

// File: rtl/rr_picker.sv
// Rotating priority encoder over the low-priority requesters 1..N-1.
// Searches last_lp+1 upward, wrapping back to 1; last_lp itself is checked last.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:1]  lp_req,
    input  logic [IW-1:0] last_lp,
    output logic [IW-1:0] winner,
    output logic          valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        // walk from the farthest offset down so the nearest requester wins
        for (int i = N - 1; i >= 1; i--) begin
            if (lp_req[((int'(last_lp) - 1 + i) % (N - 1)) + 1]) begin
                winner = IW'(((int'(last_lp) - 1 + i) % (N - 1)) + 1);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Shared bus arbiter: module 0 preempts, modules 1..N-1 share round-robin with a time quantum.
// Optional hold watchdog is built when ARB_WATCHDOG_EN is defined.
//
// state    | meaning
// IDLE     | no grant, arbitrate every edge
// GRANT_HP | module 0 owns the bus until done[0]
// GRANT_LP | LP module owns the bus; quantum and preemption apply
module shared_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 3,
    parameter int QUANTUM  = 4,
    parameter int CW       = 8,
    parameter int WD_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    shared_bus_arbiter_if.slave  bus
);

    localparam int            IW     = (N > 1) ? $clog2(N) : 1;
    localparam int            SW     = $clog2(QUANTUM + 1);
    localparam logic [CW-1:0] PC_MAX = '1;

    if (N < 2 || QUANTUM < 1 || WD_LIMIT < 1) begin : g_param_check
        $error("shared_bus_arbiter: invalid parameter set");
    end

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] rid_q, rid_d;
    logic          rvld_q, rvld_d;
    logic [SW-1:0] slice_q, slice_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [N-1:0]  grant_q;
    logic          busy_q;

    logic          wd_fire;
    logic          excl_owner;
    logic          do_arb;
    logic          new_grant;
    logic [N-1:0]  owner_oh;
    logic [N-1:0]  arb_mask;
    logic [IW-1:0] rr_base;
    logic [IW-1:0] pick;
    logic          pick_vld;

    // A releasing LP owner becomes the RR pointer so it goes to the back of the line;
    // the owner is masked out when it must not win this edge (quantum or watchdog).
    assign owner_oh   = N'(onehot(int'(owner_q)));
    assign rr_base    = (state_q == GRANT_LP) ? owner_q : last_q;
    assign excl_owner = wd_fire || (state_q == GRANT_LP && !bus.done[owner_q]);
    assign arb_mask   = excl_owner ? (bus.req & ~owner_oh) : bus.req;

    rr_picker #(.N(N), .IW(IW)) u_rr_picker (
        .lp_req  (arb_mask[N-1:1]),
        .last_lp (rr_base),
        .winner  (pick),
        .valid   (pick_vld)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        rid_d     = rid_q;
        rvld_d    = rvld_q;
        slice_d   = slice_q;
        pcnt_d    = pcnt_q;
        do_arb    = 1'b0;
        new_grant = 1'b0;

        case (state_q)
            IDLE:     do_arb = 1'b1;
            GRANT_HP: do_arb = bus.done[HP_IDX] || wd_fire;
            GRANT_LP: begin
                if (bus.done[owner_q] || wd_fire) begin
                    do_arb = 1'b1;
                end else if (bus.req[HP_IDX]) begin
                    state_d   = GRANT_HP;
                    owner_d   = '0;
                    rid_d     = owner_q;
                    rvld_d    = 1'b1;
                    new_grant = 1'b1;
                    if (pcnt_q != PC_MAX) pcnt_d = pcnt_q + 1'b1;
                end else if (slice_q == SW'(QUANTUM)) begin
                    if (pick_vld) begin
                        owner_d   = pick;
                        last_d    = pick;
                        new_grant = 1'b1;
                    end else begin
                        slice_d = SW'(1);
                    end
                end else begin
                    slice_d = slice_q + 1'b1;
                end
            end
            default:  do_arb = 1'b1;
        endcase

        if (do_arb) begin
            if (arb_mask[HP_IDX]) begin
                state_d   = GRANT_HP;
                owner_d   = '0;
                new_grant = 1'b1;
            end else if (rvld_q && arb_mask[rid_q]) begin
                state_d   = GRANT_LP;
                owner_d   = rid_q;
                rvld_d    = 1'b0;
                new_grant = 1'b1;
            end else if (pick_vld) begin
                state_d   = GRANT_LP;
                owner_d   = pick;
                last_d    = pick;
                new_grant = 1'b1;
            end else begin
                state_d = IDLE;
                owner_d = '0;
            end
        end

        if (new_grant) slice_d = SW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            rid_q   <= '0;
            rvld_q  <= 1'b0;
            slice_q <= '0;
            pcnt_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rid_q   <= rid_d;
            rvld_q  <= rvld_d;
            slice_q <= slice_d;
            pcnt_q  <= pcnt_d;
            grant_q <= (state_d == IDLE) ? '0 : N'(onehot(int'(owner_d)));
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.grant       = grant_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.preempt_cnt = pcnt_q;

`ifdef ARB_WATCHDOG_EN
    localparam int HW = $clog2(WD_LIMIT + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          wd_err_q;
    logic [IW-1:0] wd_id_q;

    // a quantum restart keeps the same owner, so the hold count keeps running
    assign wd_fire = (state_q != IDLE) && !bus.done[owner_q] && (hold_q == HW'(WD_LIMIT));

    always_comb begin
        hold_d = hold_q + 1'b1;
        if (new_grant)             hold_d = HW'(1);
        else if (state_d == IDLE)  hold_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q   <= '0;
            wd_err_q <= 1'b0;
            wd_id_q  <= '0;
        end else begin
            hold_q   <= hold_d;
            wd_err_q <= wd_fire;
            if (wd_fire) wd_id_q <= owner_q;
        end
    end

    assign bus.wd_err = wd_err_q;
    assign bus.wd_id  = wd_id_q;
`else
    assign wd_fire    = 1'b0;
    assign bus.wd_err = 1'b0;
    assign bus.wd_id  = '0;
`endif

endmodule
